// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter onto one picorv32-style native bus.
// Grant is held until the slave completes. One idle cycle separates transactions.
// Optional forced completion of a hung slave is enabled by defining ARB_TIMEOUT_EN.

// Per-master response path: only the owner sees the slave response.
module mem_arbiter_port #(
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        sel,
  input  logic        valid,
  input  logic        s_ready,
  input  logic        tmo,
  input  logic [31:0] s_rdata,
  output logic        ready,
  output logic [31:0] rdata
);
  // ready only while this master owns the bus and still requests; a forced completion substitutes TIMEOUT_DATA
  always_comb begin
    ready = sel & valid & (s_ready | tmo);
    rdata = '0;
    if (sel) rdata = tmo ? TIMEOUT_DATA : s_rdata;
  end
endmodule

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_24,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_flag
);
  localparam int NUM_M = 2;

  typedef enum logic {IDLE = 1'b0, GNT = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [NUM_M-1:0]            grant_q, grant_nxt;
  logic                        last_q, last_nxt;   // index of the master that last completed
  logic [NUM_M-1:0]            m_valid;
  logic [NUM_M-1:0][31:0]      m_addr, m_wdata;
  logic [NUM_M-1:0][3:0]       m_wstrb;
  logic [NUM_M-1:0]            p_ready;
  logic [NUM_M-1:0][31:0]      p_rdata;
  logic                        in_gnt, gidx, g_valid, tmo;

  assign m_valid = {m1_valid, m0_valid};
  assign m_addr  = {m1_addr,  m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};
  assign m_wstrb = {m1_wstrb, m0_wstrb};

  assign in_gnt  = (state == GNT);
  // grant_q is one-hot in GNT, so bit 1 is the owner index; meaningless in IDLE and always gated by in_gnt
  assign gidx    = grant_q[1];
  assign g_valid = m_valid[gidx];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          tflag_q;

  // wait_cnt reads k-1 in the k-th GNT cycle, so the forced completion lands on GNT cycle TIMEOUT_CYCLES,
  // the cycle in which the count reaches TIMEOUT_CYCLES; s_ready in that cycle takes precedence
  assign tmo = in_gnt & g_valid & ~s_ready & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter: zero while idle so every grant starts from 0, saturating while the slave stalls
  always_ff @(posedge clk_24 or negedge resetn) begin
    if (!resetn)                           wait_cnt <= '0;
    else if (!in_gnt)                      wait_cnt <= '0;
    else if (!s_ready && wait_cnt != '1)   wait_cnt <= wait_cnt + CW'(1);
  end

  // Sticky record that some transaction was force-completed
  always_ff @(posedge clk_24 or negedge resetn) begin
    if (!resetn)  tflag_q <= 1'b0;
    else if (tmo) tflag_q <= 1'b1;
  end

  assign timeout_flag = tflag_q;
`else
  // No forced completion: a hung slave keeps the grant until its master gives up
  assign tmo          = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State, owner and round-robin history registers
  always_ff @(posedge clk_24 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;   // master 0 wins the first tie
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
    end
  end

  // Arbitrate in IDLE, release on completion, abort or forced completion
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (|m_valid) begin
          state_nxt = GNT;
          if (&m_valid) grant_nxt = last_q ? 2'b01 : 2'b10;
          else          grant_nxt = m_valid;
        end
      end
      GNT: begin
        if (!g_valid) begin
          // master withdrew: release without touching the round-robin history
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (s_ready || tmo) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          last_nxt  = gidx;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign s_valid = in_gnt & g_valid & ~tmo;
  assign s_addr  = in_gnt ? m_addr[gidx]  : '0;
  assign s_wdata = in_gnt ? m_wdata[gidx] : '0;
  assign s_wstrb = in_gnt ? m_wstrb[gidx] : '0;
  assign grant   = grant_q;

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    mem_arbiter_port #(.TIMEOUT_DATA(TIMEOUT_DATA)) u_port (
      .sel     (grant_q[i]),
      .valid   (m_valid[i]),
      .s_ready (s_ready),
      .tmo     (tmo),
      .s_rdata (s_rdata),
      .ready   (p_ready[i]),
      .rdata   (p_rdata[i])
    );
  end

  assign m0_ready = p_ready[0];
  assign m0_rdata = p_rdata[0];
  assign m1_ready = p_ready[1];
  assign m1_rdata = p_rdata[1];

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter sharing one picorv32-style native memory bus (valid/ready/addr/wdata/wstrb/rdata) between master 0 (CPU) and master 1 (DMA or second bus master).
- Sits between the masters and the system address decode/read mux.
- Round-robin grant, held until the slave completes.
- One idle cycle between transactions.

Parameters:
- TIMEOUT_CYCLES, 255: cycles a granted transaction may wait for s_ready before forced completion. Used only with ARB_TIMEOUT_EN.
- TIMEOUT_DATA, 32'hDEAD_BEEF: rdata returned on a forced completion.

Ports:
- clk_24  input  1  system clock; all state changes on the rising edge
- resetn  input  1  asynchronous active-low reset
- m0_valid  input  1  master 0 request
- m0_addr  input  32  master 0 address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 byte write strobes; 0 = read
- m0_ready  output  1  master 0 completion strobe
- m0_rdata  output  32  master 0 read data
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as master 0, for master 1
- s_valid  output  1  request to slave side
- s_addr  output  32  forwarded address
- s_wdata  output  32  forwarded write data
- s_wstrb  output  4  forwarded strobes
- s_ready  input  1  slave completion
- s_rdata  input  32  slave read data
- grant  output  2  one-hot current owner; 00 when idle
- timeout_flag  output  1  sticky forced-completion indicator

Behaviour:
- States:
  - IDLE: grant=00, s_valid=0.
  - GNT: one grant bit set.
- Reset (async, resetn=0): state=IDLE, grant=00, last_grant=1 (master 0 wins first tie), timeout_flag=0, counter=0. s_valid drops immediately, including mid-transaction. No m_ready is issued for an aborted transfer.
- IDLE->GNT on the clock after any mx_valid=1. Arbitration latency is 1 cycle: s_valid rises the cycle after the request is seen.
  - Only one valid: grant it.
  - Both valid: grant the master not equal to last_grant.
- In GNT with grant=g:
  - s_valid = mg_valid.
  - s_addr/s_wdata/s_wstrb = master g's signals, combinational pass-through.
  - mg_ready = s_ready, combinational.
  - mg_rdata = s_rdata.
- Non-granted master: ready=0, rdata=0. In IDLE, s_addr/s_wdata/s_wstrb = 0.
- GNT->IDLE on the clock where s_ready=1; last_grant <= g. Next grant is decided in IDLE, so back-to-back transactions cost 1 idle cycle. A master that still holds valid after its ready competes normally; round-robin prevents starvation.
- Granted master drops valid before s_ready (abort): GNT->IDLE next clock, last_grant unchanged, no ready issued.
- s_ready while IDLE: ignored, no m_ready.
- Simultaneous new request from the other master during GNT: held off until IDLE, then wins round-robin.
- Wait counter: cleared on entry to GNT, increments each GNT cycle without s_ready, saturates at all-ones. Width is clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - When the counter reaches TIMEOUT_CYCLES with s_ready still 0, the arbiter asserts mg_ready for one cycle with mg_rdata=TIMEOUT_DATA.
  - s_valid is forced low in that cycle.
  - timeout_flag is set (sticky until reset).
  - State goes to IDLE and last_grant <= g.
  - s_ready arriving in the same cycle the counter reaches TIMEOUT_CYCLES wins: normal completion, no flag.
- Not defined:
  - The counter logic is omitted, timeout_flag is tied 0, and a hung slave holds the grant indefinitely.

Test Plan:
- m0 read addr 0x1000_0010, slave returns 0x1234_5678 after 2 cycles -> s_valid high 1 cycle after m0_valid; m0_ready one cycle with m0_rdata=0x1234_5678; grant 01 then 00; m1_ready stays 0.
- m0 and m1 both valid from reset, each re-requesting after completion, 4 transactions -> grant order m0,m1,m0,m1; each grant separated by exactly 1 IDLE cycle.
- m1 write addr 0x2000_0000, wdata 0xA5A5_0F0F, wstrb 4'b0011 -> s_addr/s_wdata/s_wstrb match exactly while grant=10; m1_ready on s_ready.
- resetn pulsed low during an m0 transaction before s_ready -> s_valid=0 and grant=00 asynchronously; no m0_ready; after release, simultaneous requests grant m0 first.
- m0 drops valid 1 cycle into its grant -> IDLE next clock, no ready; a pending m1 request is granted next.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never readies -> m0_ready on the 8th GNT cycle with rdata 0xDEAD_BEEF, timeout_flag=1 and stays set; the following m1 transaction completes normally.
